bitstream_reader: RTL and testbench

BITSTREAM_READER -- requirements
Module: bitstream_reader

---
 rtl/bitstream_reader_pkg.sv | 25 ++
 rtl/bitstream_reader_bitfield_extract.sv | 25 ++
 rtl/bitstream_reader.sv | 145 ++++++++++++++
 tb/tb_bitstream_reader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bitstream_reader_pkg.sv
// Shared widths, defaults and FSM encoding for the bitstream reader.
// Also provides the NBITS legality helper used by the reader and its extractor.
package bitstream_reader_pkg;

  localparam int ADDRESS_WIDTH = 16;
  localparam int DATA_WIDTH    = 32;
  localparam int NUM_WORDS_DEF = 512;
  localparam int BUF_W_DEF     = 64;
  localparam int NBITS_W       = 6;
  localparam int CNT_W         = 7;

  typedef enum logic [2:0] {
    FILL_REQ  = 3'd0,
    FILL_WAIT = 3'd1,
    FETCH     = 3'd2,
    LOAD      = 3'd3,
    RUN       = 3'd4,
    ACK       = 3'd5
  } state_t;

  function automatic logic nbits_legal(input logic [NBITS_W-1:0] n);
    return (n != 6'd0) && (n <= 6'd32);
  endfunction

endpackage

// File: rtl/bitstream_reader_bitfield_extract.sv
// Combinational extraction of the top NBITS bits of the MSB-aligned bit buffer,
// right-aligned into 32 bits; an illegal count yields zero.
module bitfield_extract
  import bitstream_reader_pkg::*;
#(
  parameter int BUF_W = BUF_W_DEF
) (
  input  logic [BUF_W-1:0]   data,
  input  logic [NBITS_W-1:0] nbits,
  output logic [31:0]        bits
);

  logic [BUF_W-1:0] shifted_s;

  // Shift the wanted field down to bit 0 and mask illegal counts
  always_comb begin
    shifted_s = data >> (CNT_W'(BUF_W) - {1'b0, nbits});
    if (nbits_legal(nbits)) begin
      bits = shifted_s[31:0];
    end else begin
      bits = 32'd0;
    end
  end

endmodule

// File: rtl/bitstream_reader.sv
// Bit-granular reader over a RAM buffer that is periodically refilled by an
// external fill controller; serves 1..32-bit requests in stream order.
module bitstream_reader
  import bitstream_reader_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int BUF_W     = BUF_W_DEF
) (
  input  logic                     CLOCK_I,
  input  logic                     RESETN_I,
  output logic                     FILL_START_O,
  input  logic                     FILL_DONE_I,
  output logic [ADDRESS_WIDTH-1:0] RAM_ADDR_O,
  output logic                     RAM_EN_O,
  input  logic [DATA_WIDTH-1:0]    RAM_DATA_I,
  input  logic                     REQ_I,
  input  logic [NBITS_W-1:0]       NBITS_I,
  output logic [31:0]              BITS_O,
  output logic                     VALID_O,
  output logic                     STALL_O
);

  state_t                   state_r, state_s;
  logic [BUF_W-1:0]         buffer_r, buffer_s;
  logic [CNT_W-1:0]         bitcnt_r, bitcnt_s;
  logic [CNT_W-1:0]         load_sh_s;
  logic [ADDRESS_WIDTH-1:0] rd_addr_r, rd_addr_s;
  logic                     exhausted_r, exhausted_s;
  logic                     seen_busy_r, seen_busy_s;
  logic [31:0]              bits_r, bits_s;
  logic [31:0]              extract_s;
  logic                     fill_start_r, ram_en_r, valid_r, stall_r;
  logic [ADDRESS_WIDTH-1:0] ram_addr_r;

  bitfield_extract #(.BUF_W(BUF_W)) u_extract (
    .data  (buffer_r),
    .nbits (NBITS_I),
    .bits  (extract_s)
  );

  // Next-state and datapath updates
  always_comb begin
    state_s     = state_r;
    buffer_s    = buffer_r;
    bitcnt_s    = bitcnt_r;
    rd_addr_s   = rd_addr_r;
    exhausted_s = exhausted_r;
    seen_busy_s = seen_busy_r;
    bits_s      = bits_r;
    load_sh_s   = CNT_W'(BUF_W - DATA_WIDTH) - bitcnt_r;
    case (state_r)
      FILL_REQ: begin
        seen_busy_s = 1'b0;
        state_s     = FILL_WAIT;
      end
      FILL_WAIT: begin
        // Only a DONE that was seen low first marks a completed fill
        if (!FILL_DONE_I) begin
          seen_busy_s = 1'b1;
        end else if (seen_busy_r) begin
          rd_addr_s   = {ADDRESS_WIDTH{1'b0}};
          exhausted_s = 1'b0;
          state_s     = FETCH;
        end else begin
          state_s = FILL_WAIT;
        end
      end
      FETCH: begin
        state_s = LOAD;
      end
      LOAD: begin
        buffer_s = buffer_r | ({{(BUF_W-DATA_WIDTH){1'b0}}, RAM_DATA_I} << load_sh_s);
        bitcnt_s = bitcnt_r + 7'd32;
        if (rd_addr_r == ADDRESS_WIDTH'(NUM_WORDS - 1)) begin
          exhausted_s = 1'b1;
          rd_addr_s   = {ADDRESS_WIDTH{1'b0}};
        end else begin
          rd_addr_s = rd_addr_r + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
        end
        state_s = RUN;
      end
      RUN: begin
        if (REQ_I && !nbits_legal(NBITS_I)) begin
          bits_s  = 32'd0;
          state_s = ACK;
        end else if (REQ_I && ({1'b0, NBITS_I} <= bitcnt_r)) begin
          bits_s   = extract_s;
          buffer_s = buffer_r << NBITS_I;
          bitcnt_s = bitcnt_r - {1'b0, NBITS_I};
          state_s  = ACK;
        end else if (bitcnt_r <= CNT_W'(BUF_W - DATA_WIDTH)) begin
          state_s = exhausted_r ? FILL_REQ : FETCH;
        end else begin
          state_s = RUN;
        end
      end
      ACK: begin
        state_s = RUN;
      end
      default: begin
        state_s = FILL_REQ;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      state_r      <= FILL_REQ;
      buffer_r     <= {BUF_W{1'b0}};
      bitcnt_r     <= 7'd0;
      rd_addr_r    <= {ADDRESS_WIDTH{1'b0}};
      exhausted_r  <= 1'b1;
      seen_busy_r  <= 1'b0;
      bits_r       <= 32'd0;
      fill_start_r <= 1'b0;
      ram_en_r     <= 1'b0;
      ram_addr_r   <= {ADDRESS_WIDTH{1'b0}};
      valid_r      <= 1'b0;
      stall_r      <= 1'b1;
    end else begin
      state_r      <= state_s;
      buffer_r     <= buffer_s;
      bitcnt_r     <= bitcnt_s;
      rd_addr_r    <= rd_addr_s;
      exhausted_r  <= exhausted_s;
      seen_busy_r  <= seen_busy_s;
      bits_r       <= bits_s;
      fill_start_r <= (state_r == FILL_REQ);
      // RAM strobes line up with the FETCH cycle so data lands in LOAD
      ram_en_r     <= (state_s == FETCH);
      ram_addr_r   <= rd_addr_s;
      valid_r      <= (state_s == ACK);
      stall_r      <= !((state_s == RUN) && ({1'b0, NBITS_I} <= bitcnt_s));
    end
  end

  assign FILL_START_O = fill_start_r;
  assign RAM_EN_O     = ram_en_r;
  assign RAM_ADDR_O   = ram_addr_r;
  assign BITS_O       = bits_r;
  assign VALID_O      = valid_r;
  assign STALL_O      = stall_r;

endmodule

// File: tb/tb_bitstream_reader.sv
// Scoreboard bench for bitstream_reader: RAM and fill-controller models, a
// bit-accurate stream model, and a consumer that queues expected results.
module tb_bitstream_reader;
  import bitstream_reader_pkg::*;

  localparam int NW = 512;

  logic                     clk;
  logic                     RESETN_I;
  logic                     FILL_START_O;
  logic                     FILL_DONE_I;
  logic [ADDRESS_WIDTH-1:0] RAM_ADDR_O;
  logic                     RAM_EN_O;
  logic [DATA_WIDTH-1:0]    ram_q;
  logic                     REQ_I;
  logic [NBITS_W-1:0]       NBITS_I;
  logic [31:0]              BITS_O;
  logic                     VALID_O;
  logic                     STALL_O;

  logic [31:0] mem [NW];
  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int fill_count = 0;
  int bad_rd = 0;
  int last_fetch = -1;
  int last_addr_at_fill = -1;
  int pos = 0;

  bitstream_reader #(.NUM_WORDS(NW), .BUF_W(64)) dut (
    .CLOCK_I      (clk),
    .RESETN_I     (RESETN_I),
    .FILL_START_O (FILL_START_O),
    .FILL_DONE_I  (FILL_DONE_I),
    .RAM_ADDR_O   (RAM_ADDR_O),
    .RAM_EN_O     (RAM_EN_O),
    .RAM_DATA_I   (ram_q),
    .REQ_I        (REQ_I),
    .NBITS_I      (NBITS_I),
    .BITS_O       (BITS_O),
    .VALID_O      (VALID_O),
    .STALL_O      (STALL_O)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_bits(input int p, input int n);
    logic [31:0] r;
    logic [31:0] w;
    r = 32'd0;
    for (int i = 0; i < n; i++) begin
      w = mem[((p + i) / 32) % NW];
      r = {r[30:0], w[31 - ((p + i) % 32)]};
    end
    return r;
  endfunction

  // Synchronous-read RAM, also tracking fetch addresses
  always @(posedge clk) begin
    if (RAM_EN_O) begin
      if (int'(RAM_ADDR_O) >= NW) begin
        bad_rd++;
        ram_q <= 32'd0;
      end else begin
        ram_q <= mem[RAM_ADDR_O];
      end
      last_fetch <= int'(RAM_ADDR_O);
    end
  end

  // Fill controller: DONE low for 514 cycles after each start pulse
  initial begin
    FILL_DONE_I = 1'b1;
    forever begin
      @(negedge clk);
      if (RESETN_I && FILL_START_O) begin
        fill_count++;
        last_addr_at_fill = last_fetch;
        FILL_DONE_I = 1'b0;
        repeat (514) @(negedge clk);
        FILL_DONE_I = 1'b1;
      end
    end
  end

  // Scoreboard: compare each VALID pulse against the oldest expectation
  always @(negedge clk) begin
    if (RESETN_I && VALID_O) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check_val("bits", BITS_O, exp_q.pop_front());
      end
    end
  end

  task automatic do_req(input int n);
    logic done;
    logic [NBITS_W-1:0] nb;
    nb = NBITS_W'(n);
    done = 1'b0;
    @(posedge clk);
    #1;
    if (nbits_legal(nb)) begin
      exp_q.push_back(model_bits(pos, n));
      pos += n;
    end else begin
      exp_q.push_back(32'd0);
    end
    REQ_I = 1'b1;
    NBITS_I = nb;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (VALID_O) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      check_val("req_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    REQ_I = 1'b0;
  endtask

  initial begin
    logic seen;
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'h12345678;
    RESETN_I = 1'b0;
    REQ_I = 1'b0;
    NBITS_I = 6'd0;
    repeat (3) @(negedge clk);
    check_val("rst_fill_start", 32'(FILL_START_O), 32'd0);
    check_val("rst_ram_en", 32'(RAM_EN_O), 32'd0);
    check_val("rst_ram_addr", 32'(RAM_ADDR_O), 32'd0);
    check_val("rst_valid", 32'(VALID_O), 32'd0);
    check_val("rst_bits", BITS_O, 32'd0);
    check_val("rst_stall", 32'(STALL_O), 32'd1);
    RESETN_I = 1'b1;

    // A request pending across the initial fill, interrupted by reset in LOAD
    REQ_I = 1'b1;
    NBITS_I = 6'd32;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (RAM_EN_O) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("first_fetch_seen", 32'(seen), 32'd1);
    check_val("first_fetch_addr", 32'(RAM_ADDR_O), 32'd0);
    check_val("fill_pulses_1", 32'(fill_count), 32'd1);
    @(posedge clk);
    #1;
    RESETN_I = 1'b0;
    REQ_I = 1'b0;
    #1;
    check_val("load_rst_fill_start", 32'(FILL_START_O), 32'd0);
    check_val("load_rst_ram_en", 32'(RAM_EN_O), 32'd0);
    check_val("load_rst_ram_addr", 32'(RAM_ADDR_O), 32'd0);
    check_val("load_rst_valid", 32'(VALID_O), 32'd0);
    check_val("load_rst_bits", BITS_O, 32'd0);
    check_val("load_rst_stall", 32'(STALL_O), 32'd1);
    repeat (2) @(negedge clk);
    RESETN_I = 1'b1;
    repeat (10) @(negedge clk);
    check_val("fill_pulses_2", 32'(fill_count), 32'd2);

    // Fresh stream: span word0/word1 boundary, illegal counts, then drain
    pos = 0;
    do_req(24);
    do_req(16);
    do_req(0);
    do_req(40);
    do_req(8);
    do_req(16);
    for (int k = 0; k < NW - 2; k++) do_req(32);
    do_req(4);
    do_req(8);
    do_req(20);
    repeat (5) @(negedge clk);
    check_val("fill_pulses_3", 32'(fill_count), 32'd3);
    check_val("refill_after_word", 32'(last_addr_at_fill), 32'd511);
    check_val("no_bad_addr", 32'(bad_rd), 32'd0);
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
